apb_cmd_master: RTL and testbench
=================================

# apb_cmd_master

APB4 initiator that turns a single-beat command/response stream into APB SETUP/ACCESS transfers, driving the same APB signal set our peripheral slaves (e.g. the PIO APB port) consume. Sits between an internal command source (debug bridge, DMA descriptor engine, test sequencer) and an APB slave or APB interconnect segment. One transfer is in flight at a time. A programmable wait-state timeout converts a hung slave into an error response.

## Interface
Parameters:
- AW, 12, APB address width (PADDR and cmd_addr).
- TIMEOUT, 255, max ACCESS cycles waiting for PREADY before abort; 0 disables the timeout.

Ports:
- clk  in  1  single clock for command, response and APB sides.
- reset  in  1  synchronous, active-high.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  command accepted when cmd_valid & cmd_ready.
- cmd_addr  in  AW  byte address.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_wdata  in  32  write data.
- cmd_strb  in  4  write byte strobes.
- cmd_prot  in  3  protection attributes.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  response consumed when rsp_valid & rsp_ready.
- rsp_rdata  out  32  read data; 0 for writes and timeouts.
- rsp_err  out  1  PSLVERR or timeout.
- rsp_timeout  out  1  transfer aborted by timeout.
- PADDR  out  AW  APB address, bits [1:0] forced 0.
- PSEL  out  1  APB select.
- PENABLE  out  1  APB enable.
- PWRITE  out  1  APB direction.
- PSTRB  out  4  cmd_strb on writes, 4'b0000 on reads.
- PPROT  out  3  APB protection.
- PWDATA  out  32  APB write data.
- APBACTIVE  out  1  high from SETUP through last ACCESS cycle (clock-gating hint).
- PRDATA  in  32  APB read data.
- PREADY  in  1  APB ready.
- PSLVERR  in  1  APB error, valid only with PREADY.

## Operation
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE: cmd_ready=1. On handshake, register addr/write/wdata/strb/prot, go SETUP.
- SETUP (exactly one cycle): PSEL=1, PENABLE=0, APB address/control/data valid; go ACCESS.
- ACCESS: PSEL=1, PENABLE=1, all APB outputs held stable. Wait counter increments each ACCESS cycle with PREADY=0.
  - PREADY=1: capture PRDATA (reads only, else 0), rsp_err=PSLVERR, rsp_timeout=0; go RESP.
  - PREADY=0 and TIMEOUT!=0 and counter reaches TIMEOUT: abort; rsp_rdata=0, rsp_err=1, rsp_timeout=1; go RESP.
- RESP: PSEL=PENABLE=APBACTIVE=0; rsp_valid=1, response fields stable until rsp_ready; on handshake go IDLE.
- cmd_ready=0 in SETUP, ACCESS, RESP; commands are never dropped, only back-pressured.
- cmd_addr[1:0] ignored (word-aligned bus). PSLVERR and PRDATA ignored when PREADY=0.
- Wait counter: width clog2(TIMEOUT+1), cleared on entry to SETUP, saturates.

## Timing
- Reset values: cmd_ready=0 during reset, 1 on first cycle after; rsp_valid, rsp_rdata, rsp_err, rsp_timeout, PSEL, PENABLE, PWRITE, PADDR, PSTRB, PPROT, PWDATA, APBACTIVE all 0.
- Command accepted on edge N: SETUP cycle N+1, ACCESS from N+2. PREADY=1 in first ACCESS cycle gives rsp_valid in cycle N+3 (minimum latency 3).
- Each PREADY=0 ACCESS cycle adds one cycle. Timeout: abort after TIMEOUT ACCESS cycles with PREADY=0; rsp_valid the next cycle.
- rsp_ready held high: next cmd accepted in the cycle after the response handshake (IDLE cycle); back-to-back throughput one transfer per 4 cycles minimum.
- PREADY=1 in the cycle the timeout would fire: completion wins, rsp_timeout=0.
- Reset asserted in any state: next edge returns to IDLE with all outputs at reset values; in-flight transfer and pending response are discarded.

## Test plan
- Read, slave zero-wait, PRDATA=32'hDEADBEEF, cmd_addr=12'h013 -> PADDR=12'h010, PSTRB=0, PSEL/PENABLE sequence 10,11, rsp_valid 3 cycles after accept, rsp_rdata=32'hDEADBEEF, rsp_err=0.
- Write 32'hA5A5_0001, strb 4'b0011, slave inserts 4 wait states -> PSEL/PENABLE/PADDR/PWDATA/PSTRB stable for 5 ACCESS cycles, rsp_valid at accept+7, rsp_rdata=0.
- Read with PSLVERR=1 on PREADY -> rsp_err=1, rsp_timeout=0; PSLVERR=1 with PREADY=0 earlier is ignored.
- TIMEOUT=8, PREADY stuck 0 -> 8 ACCESS cycles, PSEL drops, rsp_err=1, rsp_timeout=1, rsp_rdata=0; PREADY rising in cycle 8 instead -> normal completion.
- rsp_ready held low 10 cycles with cmd_valid high -> cmd_ready stays 0, response stable; after rsp handshake next command SETUP occurs 2 cycles later.
- Reset pulsed during ACCESS -> next cycle PSEL=PENABLE=rsp_valid=0, cmd_ready=1 after reset releases, no response emitted for aborted transfer.

Source files
------------

// File: rtl/apb_cmd_master.sv
// apb_cmd_master: single-outstanding APB4 initiator.
// Converts a valid/ready command stream into APB SETUP/ACCESS transfers and
// returns one response per command. A wait-state counter turns a slave that
// never asserts PREADY into an error response carrying a timeout flag.
module apb_cmd_master #(
  parameter int AW      = 12,
  parameter int TIMEOUT = 255
) (
  input  logic          clk,
  input  logic          reset,
  // command side
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [AW-1:0] cmd_addr,
  input  logic          cmd_write,
  input  logic [31:0]   cmd_wdata,
  input  logic [3:0]    cmd_strb,
  input  logic [2:0]    cmd_prot,
  // response side
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [31:0]   rsp_rdata,
  output logic          rsp_err,
  output logic          rsp_timeout,
  // APB side
  output logic [AW-1:0] PADDR,
  output logic          PSEL,
  output logic          PENABLE,
  output logic          PWRITE,
  output logic [3:0]    PSTRB,
  output logic [2:0]    PPROT,
  output logic [31:0]   PWDATA,
  output logic          APBACTIVE,
  input  logic [31:0]   PRDATA,
  input  logic          PREADY,
  input  logic          PSLVERR
);

  // counter must be able to hold TIMEOUT itself; keep at least one bit when disabled
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic          write;
    logic [31:0]   wdata;
    logic [3:0]    strb;
    logic [2:0]    prot;
  } req_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
    logic        timeout;
  } rsp_t;

  state_t        state, state_nxt;
  req_t          req_q;
  rsp_t          rsp_q, rsp_d;
  logic [CW-1:0] wait_cnt, wait_inc;
  logic          cmd_fire, rsp_fire, tmo_hit, acc_done;

  assign cmd_fire = cmd_valid & cmd_ready;
  assign rsp_fire = rsp_valid & rsp_ready;

  // saturating increment; abort when this ACCESS cycle would be the TIMEOUT-th unready one
  assign wait_inc = (wait_cnt == {CW{1'b1}}) ? wait_cnt : wait_cnt + CW'(1);
  assign tmo_hit  = (TIMEOUT != 0) && !PREADY && (wait_inc == CW'(TIMEOUT));
  assign acc_done = (state == ACCESS) && (PREADY || tmo_hit);

  // state register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // next-state logic; completion takes priority over timeout via PREADY in tmo_hit
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:   if (cmd_fire) state_nxt = SETUP;
      SETUP:  state_nxt = ACCESS;
      ACCESS: if (PREADY || tmo_hit) state_nxt = RESP;
      RESP:   if (rsp_fire) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // state-decoded outputs; cmd_ready is masked while reset is held
  always_comb begin
    cmd_ready = 1'b0;
    PSEL      = 1'b0;
    PENABLE   = 1'b0;
    rsp_valid = 1'b0;
    unique case (state)
      IDLE:   cmd_ready = !reset;
      SETUP:  PSEL = 1'b1;
      ACCESS: begin PSEL = 1'b1; PENABLE = 1'b1; end
      RESP:   rsp_valid = 1'b1;
      default: ;
    endcase
    APBACTIVE = PSEL;
  end

  // command capture: word-align the address and zero strobes on reads up front
  always_ff @(posedge clk) begin
    if (reset) begin
      req_q <= '0;
    end else if (cmd_fire) begin
      req_q.addr  <= {cmd_addr[AW-1:2], 2'b00};
      req_q.write <= cmd_write;
      req_q.wdata <= cmd_wdata;
      req_q.strb  <= cmd_write ? cmd_strb : 4'b0000;
      req_q.prot  <= cmd_prot;
    end
  end

  // wait-state counter, restarted for every transfer
  always_ff @(posedge clk) begin
    if (reset)                          wait_cnt <= '0;
    else if (cmd_fire)                  wait_cnt <= '0;
    else if (state == ACCESS && !PREADY) wait_cnt <= wait_inc;
  end

  // response value at the end of ACCESS: slave completion or timeout abort
  always_comb begin
    rsp_d = '0;
    if (PREADY) begin
      rsp_d.rdata   = req_q.write ? 32'h0 : PRDATA;
      rsp_d.err     = PSLVERR;
      rsp_d.timeout = 1'b0;
    end else begin
      rsp_d.err     = 1'b1;
      rsp_d.timeout = 1'b1;
    end
  end

  // response register, held stable through RESP back-pressure
  always_ff @(posedge clk) begin
    if (reset)         rsp_q <= '0;
    else if (acc_done) rsp_q <= rsp_d;
  end

  assign PADDR       = req_q.addr;
  assign PWRITE      = req_q.write;
  assign PWDATA      = req_q.wdata;
  assign PSTRB       = req_q.strb;
  assign PPROT       = req_q.prot;
  assign rsp_rdata   = rsp_q.rdata;
  assign rsp_err     = rsp_q.err;
  assign rsp_timeout = rsp_q.timeout;

endmodule

// File: tb/tb_apb_cmd_master.sv
// tb_apb_cmd_master: scenario tasks plus randomized transfers against a
// transaction-level expectation (latency, ACCESS count, response fields).
module tb_apb_cmd_master;
  localparam int AW  = 12;
  localparam int TMO = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          cmd_valid, cmd_ready, cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [31:0]   cmd_wdata;
  logic [3:0]    cmd_strb;
  logic [2:0]    cmd_prot;
  logic          rsp_valid, rsp_ready, rsp_err, rsp_timeout;
  logic [31:0]   rsp_rdata;
  logic [AW-1:0] PADDR;
  logic          PSEL, PENABLE, PWRITE, APBACTIVE, PREADY, PSLVERR;
  logic [3:0]    PSTRB;
  logic [2:0]    PPROT;
  logic [31:0]   PWDATA, PRDATA;

  int vec = 0;
  int err = 0;

  always #5 clk = ~clk;

  apb_cmd_master #(.AW(AW), .TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
    .cmd_write(cmd_write), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb), .cmd_prot(cmd_prot),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
    .PADDR(PADDR), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PSTRB(PSTRB),
    .PPROT(PPROT), .PWDATA(PWDATA), .APBACTIVE(APBACTIVE),
    .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  task automatic tick;
    @(posedge clk); #1;
  endtask

  // One complete transfer: acts as the APB slave (waits unready cycles, then
  // PREADY) and checks the bus and the response against the transaction model.
  task automatic do_xfer(input bit wr, input logic [AW-1:0] a, input logic [31:0] wd,
                         input logic [3:0] st, input logic [2:0] pr, input int waits,
                         input bit slverr, input logic [31:0] rd, input int hold,
                         input bit offer, input string tag);
    logic [AW-1:0] e_addr;
    logic [3:0]    e_strb;
    logic [31:0]   e_rdata;
    bit            e_to, e_err;
    int            e_acc, e_lat, cyc, acc;
    e_addr  = a & ~AW'(3);
    e_strb  = wr ? st : 4'b0000;
    e_to    = (waits >= TMO);
    e_acc   = e_to ? TMO : waits + 1;
    e_lat   = 2 + e_acc;
    e_rdata = (wr || e_to) ? 32'h0 : rd;
    e_err   = e_to ? 1'b1 : slverr;

    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_wdata = wd;
    cmd_strb = st; cmd_prot = pr;
    vec++;
    if (cmd_ready !== 1'b1) begin
      err++; $display("FAIL %s cmd_ready_idle: got %b want 1", tag, cmd_ready);
    end
    tick;
    // scramble command inputs so the bus must come from captured values
    cmd_valid = 1'b0; cmd_addr = AW'($urandom); cmd_wdata = $urandom;
    cmd_strb = 4'($urandom); cmd_prot = 3'($urandom); cmd_write = 1'($urandom);
    cyc = 1; acc = 0;
    while (rsp_valid !== 1'b1 && cyc < 40) begin
      vec++;
      if ({PSEL, APBACTIVE, PENABLE, PWRITE, PADDR, PSTRB, PPROT} !==
          {1'b1, 1'b1, 1'(cyc > 1), wr, e_addr, e_strb, pr} || (wr && PWDATA !== wd)) begin
        err++;
        $display("FAIL %s apb_bus cyc %0d: got sel%b act%b en%b wr%b a%h s%h p%h d%h want sel1 act1 en%b wr%b a%h s%h p%h d%h",
                 tag, cyc, PSEL, APBACTIVE, PENABLE, PWRITE, PADDR, PSTRB, PPROT, PWDATA,
                 1'(cyc > 1), wr, e_addr, e_strb, pr, wd);
      end
      if (cyc > 1) begin
        acc++;
        PREADY  = (acc > waits);
        PSLVERR = (acc > waits) ? slverr : 1'($urandom);
        PRDATA  = (acc > waits) ? rd : $urandom;
      end else begin
        PREADY = 1'b0; PSLVERR = 1'($urandom); PRDATA = $urandom;
      end
      tick; cyc++;
    end
    PREADY = 1'b0; PSLVERR = 1'b0;

    vec++;
    if (cyc !== e_lat || acc !== e_acc) begin
      err++; $display("FAIL %s latency: got %0d cyc/%0d access want %0d cyc/%0d access",
                      tag, cyc, acc, e_lat, e_acc);
    end
    for (int h = 0; h <= hold; h++) begin
      vec++;
      if ({rsp_valid, rsp_rdata, rsp_err, rsp_timeout, PSEL, PENABLE, APBACTIVE, cmd_ready} !==
          {1'b1, e_rdata, e_err, e_to, 3'b000, 1'b0}) begin
        err++;
        $display("FAIL %s response hold %0d: got v%b d%h e%b t%b sel%b en%b act%b rdy%b want v1 d%h e%b t%b sel0 en0 act0 rdy0",
                 tag, h, rsp_valid, rsp_rdata, rsp_err, rsp_timeout, PSEL, PENABLE,
                 APBACTIVE, cmd_ready, e_rdata, e_err, e_to);
      end
      if (h < hold) begin
        rsp_ready = 1'b0; cmd_valid = offer; PRDATA = $urandom; PREADY = 1'($urandom);
        tick;
      end
    end
    rsp_ready = 1'b1; PREADY = 1'b0;
    tick;
    rsp_ready = 1'b0; cmd_valid = 1'b0;
    vec++;
    if ({rsp_valid, PSEL, cmd_ready} !== 3'b001) begin
      err++; $display("FAIL %s after_handshake: got v%b sel%b rdy%b want v0 sel0 rdy1",
                      tag, rsp_valid, PSEL, cmd_ready);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; cmd_valid = 1'b1; rsp_ready = 1'b0; PREADY = 1'b0; PSLVERR = 1'b0;
    PRDATA = 32'h0; cmd_addr = '0; cmd_write = 1'b0; cmd_wdata = '0; cmd_strb = '0; cmd_prot = '0;
    tick; tick;
    vec++;
    if ({cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout, PADDR, PSEL, PENABLE,
         PWRITE, PSTRB, PPROT, PWDATA, APBACTIVE} !== '0) begin
      err++; $display("FAIL reset_values: got rdy%b v%b d%h sel%b en%b a%h want all 0",
                      cmd_ready, rsp_valid, rsp_rdata, PSEL, PENABLE, PADDR);
    end
    cmd_valid = 1'b0; reset = 1'b0;
    tick;
    vec++;
    if ({cmd_ready, PSEL, rsp_valid} !== 3'b100) begin
      err++; $display("FAIL reset_release: got rdy%b sel%b v%b want rdy1 sel0 v0",
                      cmd_ready, PSEL, rsp_valid);
    end
  endtask

  task automatic test_read_zero_wait;
    do_xfer(1'b0, 12'h013, 32'h1234_5678, 4'hF, 3'b010, 0, 1'b0, 32'hDEADBEEF, 0, 1'b0, "read0");
  endtask

  task automatic test_write_waits;
    do_xfer(1'b1, 12'h2A6, 32'hA5A5_0001, 4'b0011, 3'b001, 4, 1'b0, 32'hFFFF_FFFF, 0, 1'b0, "write4");
  endtask

  task automatic test_slverr;
    do_xfer(1'b0, 12'h100, 32'h0, 4'h0, 3'b000, 3, 1'b1, 32'h0BAD_F00D, 1, 1'b0, "slverr");
  endtask

  task automatic test_timeout;
    do_xfer(1'b0, 12'h444, 32'h0, 4'h0, 3'b111, TMO, 1'b0, 32'h5555_AAAA, 0, 1'b0, "timeout");
    do_xfer(1'b1, 12'h448, 32'hCAFE_0000, 4'hC, 3'b100, TMO - 1, 1'b0, 32'h0, 0, 1'b0, "late_ready");
    do_xfer(1'b0, 12'h44C, 32'h0, 4'h0, 3'b000, TMO - 1, 1'b1, 32'h7777_1111, 0, 1'b0, "late_err");
  endtask

  task automatic test_backpressure;
    do_xfer(1'b0, 12'h0F0, 32'h0, 4'h0, 3'b000, 1, 1'b0, 32'h1357_9BDF, 10, 1'b1, "backpressure");
    do_xfer(1'b1, 12'h0F4, 32'h2468_ACE0, 4'h5, 3'b011, 0, 1'b0, 32'h0, 0, 1'b0, "b2b_next");
  endtask

  task automatic test_back_to_back;
    for (int i = 0; i < 4; i++)
      do_xfer(1'(i & 1), AW'(i * 4 + 1), 32'h1000 + i, 4'hF, 3'(i), 0, 1'b0, 32'hB0B0_0000 + i,
              0, 1'b0, "b2b");
  endtask

  task automatic test_reset_access;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 12'h3FC; cmd_strb = 4'h0; cmd_prot = 3'b0;
    tick;
    cmd_valid = 1'b0; PREADY = 1'b0;
    tick;
    vec++;
    if ({PSEL, PENABLE} !== 2'b11) begin
      err++; $display("FAIL rst_access_setup: got sel%b en%b want sel1 en1", PSEL, PENABLE);
    end
    reset = 1'b1; PREADY = 1'b1; PRDATA = 32'h9999_9999;
    tick;
    vec++;
    if ({PSEL, PENABLE, APBACTIVE, rsp_valid, cmd_ready, rsp_rdata, rsp_err, PADDR} !== '0) begin
      err++; $display("FAIL rst_access_clear: got sel%b en%b v%b rdy%b d%h a%h want all 0",
                      PSEL, PENABLE, rsp_valid, cmd_ready, rsp_rdata, PADDR);
    end
    reset = 1'b0; PREADY = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick;
      vec++;
      if ({rsp_valid, PSEL, cmd_ready} !== 3'b001) begin
        err++; $display("FAIL rst_access_idle %0d: got v%b sel%b rdy%b want v0 sel0 rdy1",
                        i, rsp_valid, PSEL, cmd_ready);
      end
    end
  endtask

  task automatic test_random;
    for (int i = 0; i < 24; i++)
      do_xfer(1'($urandom), AW'($urandom), $urandom, 4'($urandom), 3'($urandom),
              int'($urandom_range(0, 10)), 1'($urandom), $urandom,
              int'($urandom_range(0, 3)), 1'($urandom), "random");
  endtask

  initial begin
    test_reset;
    test_read_zero_wait;
    test_write_waits;
    test_slverr;
    test_timeout;
    test_backpressure;
    test_back_to_back;
    test_reset_access;
    test_random;
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

endmodule
